// File: rtl/ras_op_scheduler_if.sv
// Request and issue handshakes of the return-address-stack scheduler.
// slave = scheduler side, master = requesters plus the stack.
interface ras_op_scheduler_if #(
    parameter int AW = 64
);
    logic          jmp_valid_in;
    logic [1:0]    jmp_op_in;
    logic [AW-1:0] jmp_addr_in;
    logic          jmp_ready_out;

    logic          irq_valid_in;
    logic [AW-1:0] irq_addr_in;
    logic          irq_ready_out;

    logic          ras_valid_out;
    logic [1:0]    ras_op_out;
    logic [AW-1:0] ras_addr_out;
    logic          ras_ready_in;

    modport slave (
        input  jmp_valid_in, jmp_op_in, jmp_addr_in,
        output jmp_ready_out,
        input  irq_valid_in, irq_addr_in,
        output irq_ready_out,
        output ras_valid_out, ras_op_out, ras_addr_out,
        input  ras_ready_in
    );

    modport master (
        output jmp_valid_in, jmp_op_in, jmp_addr_in,
        input  jmp_ready_out,
        output irq_valid_in, irq_addr_in,
        input  irq_ready_out,
        input  ras_valid_out, ras_op_out, ras_addr_out,
        output ras_ready_in
    );
endinterface

// File: rtl/ras_op_scheduler.sv
// RAS op scheduler: round-robin jmp/irq arbiter, in-order queue, occupancy tracking (stats: RAS_SCHED_STATS_EN).
// Latency: accepted request appears on ras_* one cycle later; 1 op/cycle sustained.
// Backpressure: ready only to the arbitration winner while the queue is not full and no flush.
module ras_op_scheduler #(
    parameter int DEPTH  = 16,
    parameter int QDEPTH = 4,
    parameter int AW     = 64
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    ras_op_scheduler_if.slave        bus,
    input  logic                     flush_in,
    output logic [$clog2(DEPTH):0]   depth_out,
    output logic                     overflow_out,
    output logic                     underflow_out,
    output logic                     busy_out
`ifdef RAS_SCHED_STATS_EN
    ,
    output logic [15:0]              stat_push_out,
    output logic [15:0]              stat_pop_out,
    output logic [15:0]              stat_ovf_out
`endif
);

    localparam int PW = $clog2(QDEPTH);
    localparam int DW = $clog2(DEPTH) + 1;

    localparam logic [PW:0]   QFULL   = (PW+1)'(QDEPTH);
    localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [DW-1:0] DMAX    = DW'(DEPTH);
    localparam logic [DW-1:0] DEP_ONE = DW'(1);

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_PP   = 2'b11;

    typedef enum logic {
        ARB_JMP = 1'b0,
        ARB_IRQ = 1'b1
    } arb_e;

    arb_e            r_last;
    arb_e            w_last_nxt;

    logic [1:0]      r_q_op   [QDEPTH];
    logic [AW-1:0]   r_q_addr [QDEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW:0]     r_count;
    logic [PW:0]     w_count_nxt;
    logic            r_busy;

    logic [DW-1:0]   r_depth;
    logic [DW-1:0]   w_depth_nxt;
    logic            r_ovf;
    logic            r_unf;
    logic            w_ovf_nxt;
    logic            w_unf_nxt;

    logic            w_irq_win;
    logic            w_jmp_win;
    logic            w_space;
    logic            w_irq_acc;
    logic            w_jmp_acc;
    logic            w_enq;
    logic [1:0]      w_enq_op;
    logic [AW-1:0]   w_enq_addr;
    logic            w_nonempty;
    logic            w_ras_vld;
    logic            w_deq;
    logic [1:0]      w_head_op;
    logic [AW-1:0]   w_head_addr;

    // Ties go to whoever did not win last; a lone requester always wins.
    assign w_irq_win = bus.irq_valid_in & (~bus.jmp_valid_in | (r_last == ARB_JMP));
    assign w_jmp_win = bus.jmp_valid_in & ~w_irq_win;

    // Deliberately ignores the dequeue side so ras_ready_in never reaches the readies.
    assign w_space   = (r_count < QFULL) & ~flush_in;

    assign bus.irq_ready_out = w_irq_win & w_space;
    assign bus.jmp_ready_out = w_jmp_win & w_space;

    assign w_irq_acc = w_irq_win & w_space;
    assign w_jmp_acc = w_jmp_win & w_space;

    // A jump op of 00 is consumed for arbitration purposes but never queued.
    assign w_enq      = w_irq_acc | (w_jmp_acc & (bus.jmp_op_in != OP_NONE));
    assign w_enq_op   = w_irq_acc ? OP_PUSH : bus.jmp_op_in;
    assign w_enq_addr = w_irq_acc ? bus.irq_addr_in : bus.jmp_addr_in;

    assign w_nonempty  = (r_count != '0);
    assign w_head_op   = w_nonempty ? r_q_op[r_rd_ptr]   : OP_NONE;
    assign w_head_addr = w_nonempty ? r_q_addr[r_rd_ptr] : '0;
    assign w_ras_vld   = w_nonempty & ~flush_in;
    assign w_deq       = w_ras_vld & bus.ras_ready_in;

    assign bus.ras_valid_out = w_ras_vld;
    assign bus.ras_op_out    = w_head_op;
    assign bus.ras_addr_out  = w_head_addr;

    always_comb begin
        w_last_nxt = r_last;
        if (w_irq_acc) begin
            w_last_nxt = ARB_IRQ;
        end else if (w_jmp_acc) begin
            w_last_nxt = ARB_JMP;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_last <= ARB_JMP;
        end else begin
            r_last <= w_last_nxt;
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        if (flush_in) begin
            w_count_nxt = '0;
        end else if (w_enq && !w_deq) begin
            w_count_nxt = r_count + CNT_ONE;
        end else if (!w_enq && w_deq) begin
            w_count_nxt = r_count - CNT_ONE;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_busy  <= (w_count_nxt != '0);
            if (flush_in) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_enq) begin
                    r_wr_ptr <= r_wr_ptr + PTR_ONE;
                end
                if (w_deq) begin
                    r_rd_ptr <= r_rd_ptr + PTR_ONE;
                end
            end
        end
    end

    // Storage needs no reset: the count gates every read of it.
    always_ff @(posedge clk_in) begin
        if (w_enq) begin
            r_q_op[r_wr_ptr]   <= w_enq_op;
            r_q_addr[r_wr_ptr] <= w_enq_addr;
        end
    end

    always_comb begin
        w_depth_nxt = r_depth;
        w_ovf_nxt   = 1'b0;
        w_unf_nxt   = 1'b0;
        if (w_deq) begin
            case (w_head_op)
                OP_PUSH: begin
                    if (r_depth == DMAX) begin
                        w_ovf_nxt = 1'b1;
                    end else begin
                        w_depth_nxt = r_depth + DEP_ONE;
                    end
                end
                OP_POP: begin
                    if (r_depth == '0) begin
                        w_unf_nxt = 1'b1;
                    end else begin
                        w_depth_nxt = r_depth - DEP_ONE;
                    end
                end
                OP_PP: begin
                    if (r_depth == '0) begin
                        w_unf_nxt   = 1'b1;
                        w_depth_nxt = DEP_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_depth <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_depth <= w_depth_nxt;
            r_ovf   <= w_ovf_nxt;
            r_unf   <= w_unf_nxt;
        end
    end

    assign depth_out     = r_depth;
    assign overflow_out  = r_ovf;
    assign underflow_out = r_unf;
    assign busy_out      = r_busy;

`ifdef RAS_SCHED_STATS_EN
    logic [15:0] r_stat_push;
    logic [15:0] r_stat_pop;
    logic [15:0] r_stat_ovf;
    logic        w_is_push;
    logic        w_is_pop;

    assign w_is_push = w_deq & ((w_head_op == OP_PUSH) | (w_head_op == OP_PP));
    assign w_is_pop  = w_deq & ((w_head_op == OP_POP)  | (w_head_op == OP_PP));

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_stat_push <= '0;
            r_stat_pop  <= '0;
            r_stat_ovf  <= '0;
        end else begin
            if (w_is_push && (r_stat_push != 16'hFFFF)) begin
                r_stat_push <= r_stat_push + 16'd1;
            end
            if (w_is_pop && (r_stat_pop != 16'hFFFF)) begin
                r_stat_pop <= r_stat_pop + 16'd1;
            end
            if (w_ovf_nxt && (r_stat_ovf != 16'hFFFF)) begin
                r_stat_ovf <= r_stat_ovf + 16'd1;
            end
        end
    end

    assign stat_push_out = r_stat_push;
    assign stat_pop_out  = r_stat_pop;
    assign stat_ovf_out  = r_stat_ovf;
`endif

endmodule
